// File: rtl/addr_reg_file_param.sv
// Parametrised address register file (PC, SP, AR, ...) with step-sized inc/dec,
// wrap or saturate policy, SP bounds flags and two combinational read ports.
module addr_reg_file_param #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      NREGS    = 4,
  parameter int unsigned      SELW     = 2,
  parameter int unsigned      SATURATE = 0,
  parameter logic [WIDTH-1:0] SP_RESET = 16'hFFFE,
  parameter logic [WIDTH-1:0] SP_LOW   = 16'h8000,
  parameter logic [WIDTH-1:0] SP_HIGH  = 16'hFFFE
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] I,
  input  logic [NREGS-1:0] RegSel,
  input  logic [1:0]       FunSel,
  input  logic [2:0]       Step,
  input  logic [SELW-1:0]  OutCSel,
  input  logic [SELW-1:0]  OutDSel,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic             SPOvf,
  output logic             SPUnf,
  output logic             WrapEvt
);

  typedef enum logic [1:0] {
    FN_DEC  = 2'b00,
    FN_INC  = 2'b01,
    FN_LOAD = 2'b10,
    FN_CLR  = 2'b11
  } fun_e;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_eff;
  fun_e             fun;

  always_comb begin
    fun      = fun_e'(FunSel);
    step_eff = (Step == 3'd0) ? WIDTH'(1) : WIDTH'(Step);
  end

  // Bit WIDTH of the extended sum/difference is the carry/borrow out.
  always_comb begin
    wrap_d = 1'b0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      logic [WIDTH:0] sum;
      logic [WIDTH:0] diff;
      sum       = {1'b0, regs_q[k]} + {1'b0, step_eff};
      diff      = {1'b0, regs_q[k]} - {1'b0, step_eff};
      regs_d[k] = regs_q[k];
      if (RegSel[k]) begin
        case (fun)
          FN_INC: begin
            regs_d[k] = (sum[WIDTH] && (SATURATE != 0)) ? '1 : sum[WIDTH-1:0];
            wrap_d    = wrap_d | sum[WIDTH];
          end
          FN_DEC: begin
            regs_d[k] = (diff[WIDTH] && (SATURATE != 0)) ? '0 : diff[WIDTH-1:0];
            wrap_d    = wrap_d | diff[WIDTH];
          end
          FN_LOAD: regs_d[k] = I;
          FN_CLR:  regs_d[k] = '0;
          default: regs_d[k] = regs_q[k];
        endcase
      end
    end
  end

  // A fresh violation outranks FlagClr in the same cycle.
  always_comb begin
    ovf_d = FlagClr ? 1'b0 : ovf_q;
    unf_d = FlagClr ? 1'b0 : unf_q;
    if (RegSel[1]) begin
      if (regs_d[1] > SP_HIGH) ovf_d = 1'b1;
      if (regs_d[1] < SP_LOW)  unf_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned k = 0; k < NREGS; k++) begin
        regs_q[k] <= (k == 1) ? SP_RESET : '0;
      end
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NREGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    OutC = '0;
    OutD = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (32'(OutCSel) == k) OutC = regs_q[k];
      if (32'(OutDSel) == k) OutD = regs_q[k];
    end
  end

  assign SPOvf   = ovf_q;
  assign SPUnf   = unf_q;
  assign WrapEvt = wrap_q;

endmodule

// File: tb/tb_addr_reg_file_param.sv
// Scoreboard bench for addr_reg_file_param: a wrap build (defaults) and a
// saturate build with a wider read select for out-of-range reads.
module tb_addr_reg_file_param;

  localparam int W_OC = 0, W_OD = 1, W_OVF = 2, W_UNF = 3, W_WRAP = 4;
  localparam int W_SOC = 5, W_SOD = 6, W_SWRAP = 7;

  typedef struct {
    int          cyc;
    int          what;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic        Clock, Reset_n;
  logic [15:0] d_i;
  logic [3:0]  rs;
  logic [1:0]  fs;
  logic [2:0]  st;
  logic [1:0]  cs, ds;
  logic        fc;
  logic [15:0] oc, od;
  logic        ovf, unf, wrap;

  logic [15:0] s_i;
  logic [3:0]  s_rs;
  logic [1:0]  s_fs;
  logic [2:0]  s_st;
  logic [2:0]  s_cs, s_ds;
  logic        s_fc;
  logic [15:0] s_oc, s_od;
  logic        s_ovf, s_unf, s_wrap;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  addr_reg_file_param dut (
    .Clock(Clock), .Reset_n(Reset_n), .I(d_i), .RegSel(rs), .FunSel(fs),
    .Step(st), .OutCSel(cs), .OutDSel(ds), .FlagClr(fc),
    .OutC(oc), .OutD(od), .SPOvf(ovf), .SPUnf(unf), .WrapEvt(wrap)
  );

  addr_reg_file_param #(.SATURATE(1), .SELW(3)) dut_sat (
    .Clock(Clock), .Reset_n(Reset_n), .I(s_i), .RegSel(s_rs), .FunSel(s_fs),
    .Step(s_st), .OutCSel(s_cs), .OutDSel(s_ds), .FlagClr(s_fc),
    .OutC(s_oc), .OutD(s_od), .SPOvf(s_ovf), .SPUnf(s_unf), .WrapEvt(s_wrap)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [15:0] observe(input int what);
    case (what)
      W_OC:    return oc;
      W_OD:    return od;
      W_OVF:   return {15'd0, ovf};
      W_UNF:   return {15'd0, unf};
      W_WRAP:  return {15'd0, wrap};
      W_SOC:   return s_oc;
      W_SOD:   return s_od;
      W_SWRAP: return {15'd0, s_wrap};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge Clock) begin
    exp_t        e;
    logic [15:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e   = sb.pop_front();
      act = observe(e.what);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc_cnt);
      end
    end
  end

  task automatic ex(input int what, input logic [15:0] val, input string name);
    exp_t e;
    e.cyc = cyc_cnt; e.what = what; e.exp = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] r, input logic [1:0] f, input logic [2:0] s,
                       input logic [15:0] d, input logic [1:0] c, input logic [1:0] o,
                       input logic clr);
    @(posedge Clock);
    #1;
    rs = r; fs = f; st = s; d_i = d; cs = c; ds = o; fc = clr;
  endtask

  task automatic sdrive(input logic [3:0] r, input logic [1:0] f, input logic [2:0] s,
                        input logic [15:0] d, input logic [2:0] c, input logic [2:0] o);
    @(posedge Clock);
    #1;
    s_rs = r; s_fs = f; s_st = s; s_i = d; s_cs = c; s_ds = o; s_fc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1'b0;
    rs = '0; fs = '0; st = '0; d_i = '0; cs = 2'd0; ds = 2'd1; fc = 1'b0;
    s_rs = '0; s_fs = '0; s_st = '0; s_i = '0; s_cs = '0; s_ds = '0; s_fc = 1'b0;
    repeat (2) @(posedge Clock);

    drive(4'b0001, 2'b01, 3'd1, 16'h0, 2'd0, 2'd1, 1'b0);
    Reset_n = 1'b1;
    ex(W_OC, 16'h0000, "reset_pc"); ex(W_OD, 16'hFFFE, "reset_sp");
    ex(W_OVF, 16'd0, "reset_ovf"); ex(W_UNF, 16'd0, "reset_unf"); ex(W_WRAP, 16'd0, "reset_wrap");
    drive(4'b0001, 2'b01, 3'd1, 16'h0, 2'd0, 2'd1, 1'b0);
    ex(W_OC, 16'h0001, "pc_inc1");
    drive(4'b0001, 2'b01, 3'd1, 16'h0, 2'd0, 2'd1, 1'b0);
    #2 Reset_n = 1'b0;
    ex(W_OC, 16'h0000, "async_reset_pc"); ex(W_OD, 16'hFFFE, "async_reset_sp");
    ex(W_UNF, 16'd0, "async_reset_unf");
    drive(4'b0000, 2'b00, 3'd0, 16'h0, 2'd0, 2'd1, 1'b0);
    Reset_n = 1'b1;
    ex(W_OC, 16'h0000, "reset_held_pc");

    drive(4'b0100, 2'b10, 3'd0, 16'h1234, 2'd2, 2'd3, 1'b0);
    ex(W_OC, 16'h0000, "ar_before_load"); ex(W_OD, 16'h0000, "r3_before_load");
    drive(4'b0000, 2'b00, 3'd0, 16'h0, 2'd2, 2'd3, 1'b0);
    ex(W_OC, 16'h1234, "ar_loaded"); ex(W_OD, 16'h0000, "r3_unchanged");
    drive(4'b0001, 2'b10, 3'd0, 16'hFFFE, 2'd0, 2'd1, 1'b0);
    ex(W_OC, 16'h0000, "pc_unchanged"); ex(W_OD, 16'hFFFE, "sp_unchanged");
    drive(4'b0001, 2'b01, 3'd3, 16'h0, 2'd0, 2'd1, 1'b0);
    ex(W_OC, 16'hFFFE, "pc_loaded");
    drive(4'b0001, 2'b01, 3'd0, 16'h0, 2'd0, 2'd1, 1'b0);
    ex(W_OC, 16'h0001, "pc_wrap_step3"); ex(W_WRAP, 16'd1, "wrap_pulse");
    drive(4'b0010, 2'b01, 3'd2, 16'h0, 2'd1, 2'd0, 1'b0);
    ex(W_OD, 16'h0002, "pc_step0_is_1"); ex(W_OC, 16'hFFFE, "sp_pre_inc");
    ex(W_WRAP, 16'd0, "wrap_one_cycle");

    drive(4'b0000, 2'b00, 3'd0, 16'h0, 2'd1, 2'd0, 1'b0);
    ex(W_OC, 16'h0000, "sp_wrapped"); ex(W_UNF, 16'd1, "sp_unf_wrap");
    ex(W_OVF, 16'd0, "sp_no_ovf"); ex(W_WRAP, 16'd1, "sp_wrap_pulse");
    drive(4'b0000, 2'b00, 3'd0, 16'h0, 2'd1, 2'd0, 1'b1);
    ex(W_UNF, 16'd1, "unf_sticky");
    drive(4'b0010, 2'b10, 3'd0, 16'h7FFF, 2'd1, 2'd0, 1'b0);
    ex(W_UNF, 16'd0, "unf_cleared");
    drive(4'b0000, 2'b00, 3'd0, 16'h0, 2'd1, 2'd0, 1'b0);
    ex(W_OC, 16'h7FFF, "sp_load_7fff"); ex(W_UNF, 16'd1, "unf_load_low");
    drive(4'b0010, 2'b10, 3'd0, 16'h7000, 2'd1, 2'd0, 1'b1);
    drive(4'b0010, 2'b10, 3'd0, 16'hFFFF, 2'd1, 2'd0, 1'b1);
    ex(W_OC, 16'h7000, "sp_load_7000"); ex(W_UNF, 16'd1, "unf_set_wins");
    drive(4'b0010, 2'b10, 3'd0, 16'h9000, 2'd1, 2'd0, 1'b1);
    ex(W_OC, 16'hFFFF, "sp_load_ffff"); ex(W_OVF, 16'd1, "ovf_set");
    ex(W_UNF, 16'd0, "unf_clr_with_ovf");
    drive(4'b1000, 2'b10, 3'd0, 16'hABCD, 2'd1, 2'd0, 1'b0);
    ex(W_OC, 16'h9000, "sp_in_range"); ex(W_OVF, 16'd0, "ovf_cleared");
    ex(W_UNF, 16'd0, "unf_in_range");

    drive(4'b0111, 2'b11, 3'd0, 16'h0, 2'd3, 2'd2, 1'b0);
    ex(W_OC, 16'hABCD, "r3_loaded"); ex(W_OD, 16'h1234, "ar_before_clr");
    drive(4'b0000, 2'b00, 3'd0, 16'h0, 2'd0, 2'd1, 1'b0);
    ex(W_OC, 16'h0000, "multi_clr_pc"); ex(W_OD, 16'h0000, "multi_clr_sp");
    ex(W_UNF, 16'd1, "multi_clr_unf"); ex(W_OVF, 16'd0, "multi_clr_ovf");
    ex(W_WRAP, 16'd0, "clr_no_wrap");
    drive(4'b0001, 2'b00, 3'd1, 16'h0, 2'd2, 2'd3, 1'b0);
    ex(W_OC, 16'h0000, "multi_clr_ar"); ex(W_OD, 16'hABCD, "multi_r3_held");
    drive(4'b0000, 2'b00, 3'd0, 16'h0, 2'd0, 2'd1, 1'b0);
    ex(W_OC, 16'hFFFF, "pc_dec_wrap"); ex(W_WRAP, 16'd1, "dec_wrap_pulse");

    sdrive(4'b0100, 2'b10, 3'd0, 16'h0002, 3'd2, 3'd5);
    ex(W_SOC, 16'h0000, "sat_ar_reset"); ex(W_SOD, 16'h0000, "sat_sel5_zero");
    sdrive(4'b0100, 2'b00, 3'd5, 16'h0, 3'd2, 3'd7);
    ex(W_SOC, 16'h0002, "sat_ar_loaded"); ex(W_SOD, 16'h0000, "sat_sel7_zero");
    sdrive(4'b0100, 2'b10, 3'd0, 16'hFFFF, 3'd2, 3'd1);
    ex(W_SOC, 16'h0000, "sat_dec_clamp"); ex(W_SWRAP, 16'd1, "sat_dec_wrap");
    ex(W_SOD, 16'hFFFE, "sat_sp_read");
    sdrive(4'b0100, 2'b01, 3'd1, 16'h0, 3'd2, 3'd4);
    ex(W_SOC, 16'hFFFF, "sat_ar_ffff"); ex(W_SWRAP, 16'd0, "sat_load_no_wrap");
    sdrive(4'b0000, 2'b00, 3'd0, 16'h0, 3'd2, 3'd4);
    ex(W_SOC, 16'hFFFF, "sat_inc_clamp"); ex(W_SWRAP, 16'd1, "sat_inc_wrap");
    sdrive(4'b0000, 2'b00, 3'd0, 16'h0, 3'd2, 3'd4);
    ex(W_SWRAP, 16'd0, "sat_wrap_one_cycle");

    repeat (3) @(posedge Clock);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_reg_file_param.md
Name: addr_reg_file_param

Overview:
- Parametrised address register file for the datapath: N address registers (PC, SP, AR, …) of configurable width, with two independent combinational read ports (OutC to the memory address mux, OutD to the ALU).
- Adds a per-operation step size, a wrap/saturate mode, SP bounds checking with sticky overflow/underflow flags, and asynchronous active-low reset with per-register reset values.

Parameters:
- WIDTH, 16, register and data width in bits (≥ 4).
- NREGS, 4, number of address registers (2..8). Index 0 = PC, 1 = SP, 2 = AR, others general.
- SELW, 2, read-select width; must satisfy 2^SELW ≥ NREGS.
- SATURATE, 0, overflow policy for increment/decrement. 0 = modular wrap; 1 = clamp at 0 / 2^WIDTH-1.
- SP_RESET, 16'hFFFE, reset value of register 1 (SP).
- SP_LOW, 16'h8000, lowest legal SP value.
- SP_HIGH, 16'hFFFE, highest legal SP value.

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- I  in  WIDTH  load data
- RegSel  in  NREGS  one-hot/multi-hot write enable; bit k selects register k
- FunSel  in  2  00 decrement, 01 increment, 10 load I, 11 clear
- Step  in  3  step magnitude for inc/dec; 0 is treated as 1
- OutCSel  in  SELW  read select, port C
- OutDSel  in  SELW  read select, port D
- FlagClr  in  1  synchronous clear of sticky flags
- OutC  out  WIDTH  register[OutCSel]
- OutD  out  WIDTH  register[OutDSel]
- SPOvf  out  1  sticky: SP update left [SP_LOW, SP_HIGH] above SP_HIGH
- SPUnf  out  1  sticky: SP update left range below SP_LOW
- WrapEvt  out  1  one-cycle pulse: any selected register wrapped or saturated this edge

Behaviour:

Reset (asynchronous, Reset_n = 0):
- Reg0 = 0; Reg1 = SP_RESET; all others = 0.
- SPOvf = SPUnf = WrapEvt = 0.
- Reset overrides any operation in flight; release is sampled at the next rising edge.

Register update (rising edge, Reset_n = 1):
- Each register k with RegSel[k] = 1 applies FunSel independently.
- Unselected registers hold.
- Multiple selected registers all receive the same operation in the same cycle.
- Effective step s = (Step == 0) ? 1 : Step.
- Increment: Q + s computed in WIDTH+1 bits.
  - Carry out with SATURATE = 0 → result is the low WIDTH bits.
  - Carry out with SATURATE = 1 → result is all ones.
- Decrement: Q − s.
  - Borrow with SATURATE = 0 → wrap modulo 2^WIDTH.
  - Borrow with SATURATE = 1 → result is 0.
- Load: Q ← I. Clear: Q ← 0, including SP (flag check still applies).

Read ports:
- Purely combinational: the new value is visible after the edge; there is no write-through bypass in the write cycle.
- OutCSel/OutDSel ≥ NREGS → output 0.

WrapEvt:
- Registered; asserted for exactly the cycle after any edge where an inc/dec on a selected register produced a carry/borrow, in either mode.
- Deasserted otherwise.
- Load and clear never set it.

SP bounds flags:
- Evaluated on the post-update SP value whenever RegSel[1] = 1.
- New SP > SP_HIGH → set SPOvf. New SP < SP_LOW → set SPUnf.
- The comparison uses the final value after wrap/saturate.
- Flags are sticky until FlagClr = 1 or reset.
- FlagClr together with a new violation in the same cycle: set wins.
- The register always takes the computed value; the flag does not block the write.

Test Plan:
- Reset: Reset_n = 0 mid-cycle during increment of PC → OutC (sel 0) = 0 immediately; OutD (sel 1) = 16'hFFFE; all flags 0.
- Load/read: RegSel = 4'b0100, FunSel = 10, I = 16'h1234 → next cycle OutC (sel 2) = 16'h1234. Same cycle, OutCSel = 3 reads 0; other registers unchanged.
- Step and wrap (SATURATE = 0): load PC = 16'hFFFE, increment with Step = 3 → PC = 16'h0001, WrapEvt = 1 for one cycle. Step = 0 increment → PC = 16'h0002.
- Saturate (SATURATE = 1 build): AR = 16'h0002, decrement Step = 5 → AR = 0, WrapEvt = 1. Increment from 16'hFFFF → stays 16'hFFFF.
- SP bounds: SP = 16'hFFFE, increment Step = 2 → SP = 16'h0000 (wrap), SPUnf = 1, WrapEvt = 1. FlagClr with no SP update → SPUnf = 0. Load SP = 16'h7FFF → SPUnf = 1 again. FlagClr plus a simultaneous violation → flag stays 1.
- Multi-select: RegSel = 4'b0111, FunSel = 11 → PC = SP = AR = 0, SPUnf = 1 (0 < SP_LOW), reg 3 unchanged.
